// File: rtl/bridge_pkg.sv
// ---------------------------------------------------------------------------
// bridge_pkg
// Definitions shared by the AHB-to-APB bridge:
//   - state_e     : 3-bit encoding of the APB sequencing FSM (all 8 codes used)
//   - PERIPHn_*   : base/limit of the three APB peripheral windows
//   - addr_to_sel : total address decode to a one-hot peripheral select,
//                   also used by the AHB slave select logic
// ---------------------------------------------------------------------------
package bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WWAIT    = 3'd1,
        ST_READ     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_WRITEP   = 3'd4,
        ST_RENABLE  = 3'd5,
        ST_WENABLE  = 3'd6,
        ST_WENABLEP = 3'd7
    } state_e;

    localparam logic [31:0] PERIPH0_BASE  = 32'h8000_0000;
    localparam logic [31:0] PERIPH0_LIMIT = 32'h83FF_FFFF;
    localparam logic [31:0] PERIPH1_BASE  = 32'h8400_0000;
    localparam logic [31:0] PERIPH1_LIMIT = 32'h87FF_FFFF;
    localparam logic [31:0] PERIPH2_BASE  = 32'h8800_0000;
    localparam logic [31:0] PERIPH2_LIMIT = 32'h8BFF_FFFF;

    // Out-of-window addresses decode to no select so a stray transfer can
    // never strobe a peripheral.
    function automatic logic [2:0] addr_to_sel(input logic [31:0] addr);
        logic [2:0] sel;
        sel = 3'b000;
        if (addr >= PERIPH0_BASE && addr <= PERIPH0_LIMIT) begin
            sel = 3'b001;
        end else if (addr >= PERIPH1_BASE && addr <= PERIPH1_LIMIT) begin
            sel = 3'b010;
        end else if (addr >= PERIPH2_BASE && addr <= PERIPH2_LIMIT) begin
            sel = 3'b100;
        end
        return sel;
    endfunction

endpackage

// File: rtl/apb_fsm_controller_if.sv
// ---------------------------------------------------------------------------
// apb_fsm_controller_if
// Bus bundle between the AHB slave interface / APB peripherals and the
// bridge FSM controller.
//   AHB side : valid, Hwrite, Hwritereg, Haddr, Haddr1, Haddr2, Hwdata,
//              Hwdata1 (into controller), Hreadyout (out of controller)
//   APB side : Pselx, Penable, Pwrite, Paddr, Pwdata (out of controller),
//              Pready (into controller, only when APB_PREADY_EN is defined)
// Modports:
//   master : the environment driving AHB requests and observing APB
//   slave  : the controller
// ---------------------------------------------------------------------------
interface apb_fsm_controller_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSEL   = 3
);
    logic              valid;
    logic              Hwrite;
    logic              Hwritereg;
    logic [ADDR_W-1:0] Haddr;
    logic [ADDR_W-1:0] Haddr1;
    logic [ADDR_W-1:0] Haddr2;
    logic [DATA_W-1:0] Hwdata;
    logic [DATA_W-1:0] Hwdata1;
    logic [NSEL-1:0]   Pselx;
    logic              Penable;
    logic              Pwrite;
    logic [ADDR_W-1:0] Paddr;
    logic [DATA_W-1:0] Pwdata;
    logic              Hreadyout;
`ifdef APB_PREADY_EN
    logic              Pready;
`endif

    modport master (
`ifdef APB_PREADY_EN
        output Pready,
`endif
        output valid, Hwrite, Hwritereg, Haddr, Haddr1, Haddr2, Hwdata, Hwdata1,
        input  Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout
    );

    modport slave (
`ifdef APB_PREADY_EN
        input  Pready,
`endif
        input  valid, Hwrite, Hwritereg, Haddr, Haddr1, Haddr2, Hwdata, Hwdata1,
        output Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout
    );

endinterface

// File: rtl/apb_fsm_controller.sv
// ---------------------------------------------------------------------------
// apb_fsm_controller
// Bridge FSM that turns qualified AHB transfers into APB setup/enable
// phases and generates AHB wait states through Hreadyout.
// Every output is a register loaded with the value belonging to the state
// being entered.
//
// Ports:
//   Hclk      in   bridge clock, rising edge
//   Hresetn   in   synchronous active-low reset
//   bus       slave modport of apb_fsm_controller_if:
//             valid/Hwrite/Hwritereg/Haddr*/Hwdata* in,
//             Pselx/Penable/Pwrite/Paddr/Pwdata/Hreadyout out
//
// Build option:
//   APB_PREADY_EN  adds bus.Pready; an enable phase is extended (state and
//                  all P* outputs held, Hreadyout=0) while Pready=0.
//                  Without it every enable phase is a single cycle.
// ---------------------------------------------------------------------------
module apb_fsm_controller
    import bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSEL   = 3
) (
    input  logic                 Hclk,
    input  logic                 Hresetn,
    apb_fsm_controller_if.slave  bus
);

    localparam logic [2:0] S_IDLE     = ST_IDLE;
    localparam logic [2:0] S_WWAIT    = ST_WWAIT;
    localparam logic [2:0] S_READ     = ST_READ;
    localparam logic [2:0] S_WRITE    = ST_WRITE;
    localparam logic [2:0] S_WRITEP   = ST_WRITEP;
    localparam logic [2:0] S_RENABLE  = ST_RENABLE;
    localparam logic [2:0] S_WENABLE  = ST_WENABLE;
    localparam logic [2:0] S_WENABLEP = ST_WENABLEP;

    logic [2:0]        state_q,     state_d;
    logic [NSEL-1:0]   pselx_q,     pselx_d;
    logic              penable_q,   penable_d;
    logic              pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic              hreadyout_q, hreadyout_d;
    logic              pready_ok;

`ifdef APB_PREADY_EN
    assign pready_ok = bus.Pready;
`else
    assign pready_ok = 1'b1;
`endif

    function automatic logic [NSEL-1:0] decode(input logic [ADDR_W-1:0] a);
        return NSEL'(addr_to_sel(32'(a)));
    endfunction

    always_comb begin
        state_d     = state_q;
        pselx_d     = pselx_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        hreadyout_d = hreadyout_q;

        case (state_q)
            S_IDLE, S_RENABLE, S_WENABLE: begin
                if ((state_q != S_IDLE) && !pready_ok) begin
                    // Extended enable phase: hold everything, stall AHB.
                    penable_d   = 1'b1;
                    hreadyout_d = 1'b0;
                end else if (!bus.valid) begin
                    state_d     = S_IDLE;
                    pselx_d     = '0;
                    penable_d   = 1'b0;
                    hreadyout_d = 1'b1;
                end else if (bus.Hwrite) begin
                    // Write data arrives next cycle; wait for it before setup.
                    state_d     = S_WWAIT;
                    pselx_d     = '0;
                    penable_d   = 1'b0;
                    hreadyout_d = 1'b1;
                end else begin
                    state_d     = S_READ;
                    paddr_d     = bus.Haddr;
                    pwrite_d    = 1'b0;
                    pselx_d     = decode(bus.Haddr);
                    penable_d   = 1'b0;
                    hreadyout_d = 1'b0;
                end
            end

            S_WWAIT: begin
                // Address of the write is now one cycle old; its data is current.
                paddr_d   = bus.Haddr1;
                pwdata_d  = bus.Hwdata;
                pwrite_d  = 1'b1;
                pselx_d   = decode(bus.Haddr1);
                penable_d = 1'b0;
                if (bus.valid) begin
                    // A second transfer is queued behind this one: stall AHB.
                    state_d     = S_WRITEP;
                    hreadyout_d = 1'b0;
                end else begin
                    state_d     = S_WRITE;
                    hreadyout_d = 1'b1;
                end
            end

            S_READ: begin
                state_d     = S_RENABLE;
                penable_d   = 1'b1;
                hreadyout_d = 1'b1;
            end

            S_WRITEP: begin
                state_d     = S_WENABLEP;
                penable_d   = 1'b1;
                hreadyout_d = 1'b1;
            end

            S_WRITE: begin
                state_d     = bus.valid ? S_WENABLEP : S_WENABLE;
                penable_d   = 1'b1;
                hreadyout_d = 1'b1;
            end

            S_WENABLEP: begin
                if (!pready_ok) begin
                    penable_d   = 1'b1;
                    hreadyout_d = 1'b0;
                end else begin
                    // The pending transfer is two cycles behind the AHB bus.
                    paddr_d   = bus.Haddr2;
                    pwdata_d  = bus.Hwdata1;
                    pselx_d   = decode(bus.Haddr2);
                    penable_d = 1'b0;
                    if (!bus.Hwritereg) begin
                        state_d     = S_READ;
                        pwrite_d    = 1'b0;
                        hreadyout_d = 1'b0;
                    end else if (bus.valid) begin
                        state_d     = S_WRITEP;
                        pwrite_d    = 1'b1;
                        hreadyout_d = 1'b0;
                    end else begin
                        state_d     = S_WRITE;
                        pwrite_d    = 1'b1;
                        hreadyout_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d     = S_IDLE;
                pselx_d     = '0;
                penable_d   = 1'b0;
                pwrite_d    = 1'b0;
                paddr_d     = '0;
                pwdata_d    = '0;
                hreadyout_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state_q     <= S_IDLE;
            pselx_q     <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            hreadyout_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            hreadyout_q <= hreadyout_d;
        end
    end

    assign bus.Pselx     = pselx_q;
    assign bus.Penable   = penable_q;
    assign bus.Pwrite    = pwrite_q;
    assign bus.Paddr     = paddr_q;
    assign bus.Pwdata    = pwdata_q;
    assign bus.Hreadyout = hreadyout_q;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// ---------------------------------------------------------------------------
// tb_apb_fsm_controller
// Directed bench for apb_fsm_controller. The AHB pipeline registers
// (Haddr1/Haddr2/Hwdata1/Hwritereg) are produced by a small delay line here.
// Control outputs are compared as ctl = {Pselx, Penable, Pwrite, Hreadyout}.
// ---------------------------------------------------------------------------
module tb_apb_fsm_controller;

    logic Hclk;
    logic Hresetn;
    int   checks;
    int   errors;

    apb_fsm_controller_if #(.ADDR_W(32), .DATA_W(32), .NSEL(3)) bus ();

    apb_fsm_controller #(.ADDR_W(32), .DATA_W(32), .NSEL(3)) dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .bus     (bus)
    );

    logic [5:0] ctl;
    assign ctl = {bus.Pselx, bus.Penable, bus.Pwrite, bus.Hreadyout};

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    // AHB slave pipeline registers.
    always @(posedge Hclk) begin
        bus.Haddr1    <= bus.Haddr;
        bus.Haddr2    <= bus.Haddr1;
        bus.Hwdata1   <= bus.Hwdata;
        bus.Hwritereg <= bus.Hwrite;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic step();
        @(posedge Hclk);
        #1;
    endtask

    task automatic test_reset();
        Hresetn = 1'b0;
        step();
        step();
        checks++;
        if (ctl !== 6'b000_0_0_1) begin
            errors++; $display("FAIL reset_ctl got %b exp %b", ctl, 6'b000001);
        end
        checks++;
        if (bus.Paddr !== 32'h0 || bus.Pwdata !== 32'h0) begin
            errors++; $display("FAIL reset_data got %h/%h exp 0/0", bus.Paddr, bus.Pwdata);
        end
        Hresetn = 1'b1;
        step();
        checks++;
        if (ctl !== 6'b000_0_0_1) begin
            errors++; $display("FAIL reset_idle got %b exp %b", ctl, 6'b000001);
        end
    endtask

    task automatic test_single_read();
        bus.valid = 1'b1; bus.Hwrite = 1'b0; bus.Haddr = 32'h8000_0010;
        step();
        bus.valid = 1'b0;
        checks++;
        if (ctl !== 6'b001_0_0_0 || bus.Paddr !== 32'h8000_0010) begin
            errors++; $display("FAIL rd_setup got %b/%h exp %b/%h", ctl, bus.Paddr, 6'b001000, 32'h8000_0010);
        end
        step();
        checks++;
        if (ctl !== 6'b001_1_0_1) begin
            errors++; $display("FAIL rd_enable got %b exp %b", ctl, 6'b001101);
        end
        step();
        checks++;
        if (ctl !== 6'b000_0_0_1 || bus.Paddr !== 32'h8000_0010) begin
            errors++; $display("FAIL rd_idle got %b/%h exp %b/%h", ctl, bus.Paddr, 6'b000001, 32'h8000_0010);
        end
    endtask

    task automatic test_decode();
        logic [31:0] addrs [6];
        logic [2:0]  sels  [6];
        addrs = '{32'h8000_0000, 32'h83FF_FFFF, 32'h8400_0000,
                  32'h8BFF_FFFF, 32'h8C00_0000, 32'h7FFF_FFFF};
        sels  = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b000, 3'b000};
        for (int i = 0; i < 6; i++) begin
            bus.valid = 1'b1; bus.Hwrite = 1'b0; bus.Haddr = addrs[i];
            step();
            bus.valid = 1'b0;
            checks++;
            if (bus.Pselx !== sels[i] || bus.Paddr !== addrs[i]) begin
                errors++; $display("FAIL decode_%0d got %b/%h exp %b/%h", i, bus.Pselx, bus.Paddr, sels[i], addrs[i]);
            end
            step();
            step();
        end
    endtask

    task automatic test_read_back_to_back();
        bus.valid = 1'b1; bus.Hwrite = 1'b0; bus.Haddr = 32'h8400_0100;
        step();
        bus.valid = 1'b0;
        checks++;
        if (ctl !== 6'b010_0_0_0) begin
            errors++; $display("FAIL rr_setup1 got %b exp %b", ctl, 6'b010000);
        end
        step();
        bus.valid = 1'b1; bus.Haddr = 32'h8800_0200;
        step();
        bus.valid = 1'b0;
        checks++;
        if (ctl !== 6'b100_0_0_0 || bus.Paddr !== 32'h8800_0200) begin
            errors++; $display("FAIL rr_setup2 got %b/%h exp %b/%h", ctl, bus.Paddr, 6'b100000, 32'h8800_0200);
        end
        step();
        checks++;
        if (ctl !== 6'b100_1_0_1) begin
            errors++; $display("FAIL rr_enable2 got %b exp %b", ctl, 6'b100101);
        end
        step();
    endtask

    task automatic test_single_write();
        bus.valid = 1'b1; bus.Hwrite = 1'b1; bus.Haddr = 32'h8400_0004;
        step();
        bus.valid = 1'b0; bus.Hwdata = 32'hDEAD_BEEF;
        checks++;
        if (ctl !== 6'b000_0_0_1) begin
            errors++; $display("FAIL wr_wwait got %b exp %b", ctl, 6'b000001);
        end
        step();
        checks++;
        if (ctl !== 6'b010_0_1_1 || bus.Paddr !== 32'h8400_0004 || bus.Pwdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wr_setup got %b/%h/%h exp %b/%h/%h", ctl, bus.Paddr, bus.Pwdata,
                               6'b010011, 32'h8400_0004, 32'hDEAD_BEEF);
        end
        step();
        checks++;
        if (ctl !== 6'b010_1_1_1) begin
            errors++; $display("FAIL wr_enable got %b exp %b", ctl, 6'b010111);
        end
        step();
        checks++;
        if (ctl !== 6'b000_0_1_1 || bus.Pwdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wr_idle got %b/%h exp %b/%h", ctl, bus.Pwdata, 6'b000011, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_back_to_back();
        int stalls;
        stalls = 0;
        bus.valid = 1'b1; bus.Hwrite = 1'b1; bus.Haddr = 32'h8800_0000;
        step();
        stalls += (bus.Hreadyout === 1'b0) ? 1 : 0;
        bus.Haddr = 32'h8800_0004; bus.Hwdata = 32'h1111_1111;
        step();
        stalls += (bus.Hreadyout === 1'b0) ? 1 : 0;
        checks++;
        if (ctl !== 6'b100_0_1_0 || bus.Paddr !== 32'h8800_0000 || bus.Pwdata !== 32'h1111_1111) begin
            errors++; $display("FAIL b2b_setup1 got %b/%h/%h exp %b/%h/%h", ctl, bus.Paddr, bus.Pwdata,
                               6'b100010, 32'h8800_0000, 32'h1111_1111);
        end
        bus.valid = 1'b0; bus.Hwdata = 32'h2222_2222;
        step();
        stalls += (bus.Hreadyout === 1'b0) ? 1 : 0;
        checks++;
        if (ctl !== 6'b100_1_1_1) begin
            errors++; $display("FAIL b2b_enable1 got %b exp %b", ctl, 6'b100111);
        end
        step();
        stalls += (bus.Hreadyout === 1'b0) ? 1 : 0;
        checks++;
        if (ctl !== 6'b100_0_1_1 || bus.Paddr !== 32'h8800_0004 || bus.Pwdata !== 32'h2222_2222) begin
            errors++; $display("FAIL b2b_setup2 got %b/%h/%h exp %b/%h/%h", ctl, bus.Paddr, bus.Pwdata,
                               6'b100011, 32'h8800_0004, 32'h2222_2222);
        end
        step();
        stalls += (bus.Hreadyout === 1'b0) ? 1 : 0;
        checks++;
        if (ctl !== 6'b100_1_1_1) begin
            errors++; $display("FAIL b2b_enable2 got %b exp %b", ctl, 6'b100111);
        end
        step();
        stalls += (bus.Hreadyout === 1'b0) ? 1 : 0;
        checks++;
        if (ctl !== 6'b000_0_1_1) begin
            errors++; $display("FAIL b2b_idle got %b exp %b", ctl, 6'b000011);
        end
        checks++;
        if (stalls !== 1) begin
            errors++; $display("FAIL b2b_stalls got %0d exp %0d", stalls, 1);
        end
    endtask

    task automatic test_write_read();
        bus.valid = 1'b1; bus.Hwrite = 1'b1; bus.Haddr = 32'h8800_0008;
        step();
        bus.Hwrite = 1'b0; bus.Haddr = 32'h8000_0020; bus.Hwdata = 32'hCAFE_F00D;
        step();
        checks++;
        if (ctl !== 6'b100_0_1_0 || bus.Paddr !== 32'h8800_0008 || bus.Pwdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL wr_rd_wsetup got %b/%h/%h exp %b/%h/%h", ctl, bus.Paddr, bus.Pwdata,
                               6'b100010, 32'h8800_0008, 32'hCAFE_F00D);
        end
        bus.valid = 1'b0;
        step();
        checks++;
        if (ctl !== 6'b100_1_1_1) begin
            errors++; $display("FAIL wr_rd_wenable got %b exp %b", ctl, 6'b100111);
        end
        step();
        checks++;
        if (ctl !== 6'b001_0_0_0 || bus.Paddr !== 32'h8000_0020) begin
            errors++; $display("FAIL wr_rd_rsetup got %b/%h exp %b/%h", ctl, bus.Paddr, 6'b001000, 32'h8000_0020);
        end
        step();
        checks++;
        if (ctl !== 6'b001_1_0_1) begin
            errors++; $display("FAIL wr_rd_renable got %b exp %b", ctl, 6'b001101);
        end
        step();
        checks++;
        if (ctl !== 6'b000_0_0_1) begin
            errors++; $display("FAIL wr_rd_idle got %b exp %b", ctl, 6'b000001);
        end
    endtask

    task automatic test_reset_mid_transfer();
        bus.valid = 1'b1; bus.Hwrite = 1'b1; bus.Haddr = 32'h8000_0008;
        step();
        bus.valid = 1'b0; bus.Hwdata = 32'h5A5A_5A5A;
        step();
        step();
        checks++;
        if (ctl !== 6'b001_1_1_1) begin
            errors++; $display("FAIL rst_mid_wenable got %b exp %b", ctl, 6'b001111);
        end
        Hresetn = 1'b0; bus.valid = 1'b1; bus.Hwrite = 1'b0;
        step();
        checks++;
        if (ctl !== 6'b000_0_0_1 || bus.Paddr !== 32'h0 || bus.Pwdata !== 32'h0) begin
            errors++; $display("FAIL rst_mid_abort got %b/%h/%h exp %b/0/0", ctl, bus.Paddr, bus.Pwdata, 6'b000001);
        end
        step();
        Hresetn = 1'b1; bus.valid = 1'b0;
        step();
        checks++;
        if (ctl !== 6'b000_0_0_1) begin
            errors++; $display("FAIL rst_mid_idle got %b exp %b", ctl, 6'b000001);
        end
    endtask

`ifdef APB_PREADY_EN
    task automatic test_pready();
        bus.valid = 1'b1; bus.Hwrite = 1'b0; bus.Haddr = 32'h8800_0010; bus.Pready = 1'b0;
        step();
        bus.valid = 1'b0;
        step();
        checks++;
        if (ctl !== 6'b100_1_0_1) begin
            errors++; $display("FAIL pready_enter got %b exp %b", ctl, 6'b100101);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ctl !== 6'b100_1_0_0 || bus.Paddr !== 32'h8800_0010) begin
                errors++; $display("FAIL pready_hold_%0d got %b/%h exp %b/%h", i, ctl, bus.Paddr, 6'b100100, 32'h8800_0010);
            end
        end
        bus.Pready = 1'b1;
        step();
        checks++;
        if (ctl !== 6'b000_0_0_1) begin
            errors++; $display("FAIL pready_done got %b exp %b", ctl, 6'b000001);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        Hresetn    = 1'b0;
        bus.valid  = 1'b0;
        bus.Hwrite = 1'b0;
        bus.Haddr  = 32'h0;
        bus.Hwdata = 32'h0;
`ifdef APB_PREADY_EN
        bus.Pready = 1'b1;
`endif
        test_reset();
        test_single_read();
        test_decode();
        test_read_back_to_back();
        test_single_write();
        test_back_to_back();
        test_write_read();
        test_reset_mid_transfer();
`ifdef APB_PREADY_EN
        test_pready();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
